// File: rtl/operand_fetch.sv
// Operand fetch stage: 8x16 register file plus a small FSM that reads Rn then Rm
// and hands B and the latched shift code to the shifter. Macro: OPERAND_FETCH_BYPASS_EN.
module operand_fetch #(
  parameter int DW   = 16,
  parameter int NREG = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          write,
  input  logic [2:0]    writenum,
  input  logic [DW-1:0] data_in,
  input  logic          start,
  input  logic [2:0]    rn,
  input  logic [2:0]    rm,
  input  logic [1:0]    shift_in,
  input  logic          take,
  output logic [DW-1:0] a_out,
  output logic [DW-1:0] b_out,
  output logic [1:0]    shift_out,
  output logic          valid,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, RD_A, RD_B, DONE} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] rf_q [NREG];
  logic [DW-1:0] rf_d [NREG];
  logic [2:0]    rn_q, rn_d, rm_q, rm_d;
  logic [1:0]    shift_q, shift_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d;
  logic          valid_q, valid_d, busy_q, busy_d;
  logic [DW-1:0] rd_a, rd_b;

  // Captured values are the pre-write contents unless forwarding is enabled.
  always_comb begin
`ifdef OPERAND_FETCH_BYPASS_EN
    rd_a = (write && (writenum == rn_q)) ? data_in : rf_q[rn_q];
    rd_b = (write && (writenum == rm_q)) ? data_in : rf_q[rm_q];
`else
    rd_a = rf_q[rn_q];
    rd_b = rf_q[rm_q];
`endif
  end

  always_comb begin
    rf_d = rf_q;
    if (write) rf_d[writenum] = data_in;
  end

  always_comb begin
    state_d = state_q;
    rn_d    = rn_q;
    rm_d    = rm_q;
    shift_d = shift_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          rn_d    = rn;
          rm_d    = rm;
          shift_d = shift_in;
          state_d = RD_A;
        end
      end
      RD_A: begin
        a_d     = rd_a;
        state_d = RD_B;
      end
      RD_B: begin
        b_d     = rd_b;
        state_d = DONE;
      end
      DONE: begin
        if (take) begin
          if (start) begin
            rn_d    = rn;
            rm_d    = rm;
            shift_d = shift_in;
            state_d = RD_A;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == DONE);
    busy_d  = (state_d == RD_A) || (state_d == RD_B);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      rn_q    <= '0;
      rm_q    <= '0;
      shift_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rf_q    <= rf_d;
      rn_q    <= rn_d;
      rm_q    <= rm_d;
      shift_q <= shift_d;
      a_q     <= a_d;
      b_q     <= b_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign shift_out = shift_q;
  assign valid     = valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: table of fetch vectors plus hand-written
// multi-cycle sequences (back-to-back, write during RD_B, ignored start, async reset).
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        write = 1'b0;
  logic [2:0]  writenum = '0;
  logic [15:0] data_in = '0;
  logic        start = 1'b0;
  logic [2:0]  rn = '0, rm = '0;
  logic [1:0]  shift_in = '0;
  logic        take = 1'b0;
  logic [15:0] a_out, b_out;
  logic [1:0]  shift_out;
  logic        valid, busy;

  int checks = 0;
  int failures = 0;

  operand_fetch dut (
    .clk(clk), .reset(reset), .write(write), .writenum(writenum), .data_in(data_in),
    .start(start), .rn(rn), .rm(rm), .shift_in(shift_in), .take(take),
    .a_out(a_out), .b_out(b_out), .shift_out(shift_out), .valid(valid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  rn;
    logic [2:0]  rm;
    logic [1:0]  sh;
    logic [15:0] ea;
    logic [15:0] eb;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [2:0] idx, input logic [15:0] val);
    write = 1'b1; writenum = idx; data_in = val;
    @(negedge clk);
    write = 1'b0;
  endtask

  // Called at a negedge; returns one negedge later with the FSM in RD_A.
  task automatic start_fetch(input logic [2:0] a, input logic [2:0] b, input logic [1:0] s,
                             input logic tk);
    start = 1'b1; rn = a; rm = b; shift_in = s; take = tk;
    @(negedge clk);
    start = 1'b0; take = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    check(name, valid, 1);
  endtask

  task automatic do_take();
    take = 1'b1;
    @(negedge clk);
    take = 1'b0;
  endtask

  vec_t        vecs [5];
  logic [15:0] init_vals [8];
  logic [15:0] exp_b_rdb;
  int          valid_cnt;

  initial begin
    init_vals = '{16'h0F0F, 16'h1357, 16'h2468, 16'hFFFF, 16'h8000, 16'h0001, 16'hA5A5, 16'h7E7E};
    vecs[0] = '{3'd0, 3'd7, 2'b00, 16'h0F0F, 16'h7E7E};
    vecs[1] = '{3'd2, 3'd4, 2'b10, 16'h2468, 16'h8000};
    vecs[2] = '{3'd6, 3'd6, 2'b11, 16'hA5A5, 16'hA5A5};
    vecs[3] = '{3'd3, 3'd1, 2'b01, 16'hFFFF, 16'h1357};
    vecs[4] = '{3'd5, 3'd2, 2'b00, 16'h0001, 16'h2468};
`ifdef OPERAND_FETCH_BYPASS_EN
    exp_b_rdb = 16'hAAAA;
`else
    exp_b_rdb = 16'hF0CF;
`endif

    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_a", a_out, 0);
    check("rst_b", b_out, 0);
    check("rst_shift", shift_out, 0);

    for (int i = 0; i < 8; i++) do_write(i[2:0], init_vals[i]);
    for (int i = 0; i < 5; i++) begin
      start_fetch(vecs[i].rn, vecs[i].rm, vecs[i].sh, 1'b0);
      wait_valid($sformatf("vec%0d_valid", i));
      check($sformatf("vec%0d_a", i), a_out, vecs[i].ea);
      check($sformatf("vec%0d_b", i), b_out, vecs[i].eb);
      check($sformatf("vec%0d_shift", i), shift_out, vecs[i].sh);
      do_take();
    end

    // Basic fetch with exact latency and hold.
    do_write(3'd5, 16'h1234);
    do_write(3'd3, 16'hF0CF);
    start_fetch(3'd5, 3'd3, 2'b01, 1'b0);
    check("f1_rda_busy", busy, 1);
    check("f1_rda_valid", valid, 0);
    @(negedge clk);
    check("f1_rdb_busy", busy, 1);
    check("f1_rdb_valid", valid, 0);
    @(negedge clk);
    check("f1_valid", valid, 1);
    check("f1_busy", busy, 0);
    check("f1_a", a_out, 16'h1234);
    check("f1_b", b_out, 16'hF0CF);
    check("f1_shift", shift_out, 2'b01);
    repeat (3) @(negedge clk);
    check("f1_hold_valid", valid, 1);
    check("f1_hold_a", a_out, 16'h1234);
    check("f1_hold_b", b_out, 16'hF0CF);

    // Back-to-back fetch from DONE.
    start_fetch(3'd3, 3'd5, 2'b11, 1'b1);
    check("b2b_rda_valid", valid, 0);
    check("b2b_rda_busy", busy, 1);
    @(negedge clk);
    check("b2b_rdb_busy", busy, 1);
    check("b2b_rdb_a", a_out, 16'hF0CF);
    @(negedge clk);
    check("b2b_valid", valid, 1);
    check("b2b_a", a_out, 16'hF0CF);
    check("b2b_b", b_out, 16'h1234);
    check("b2b_shift", shift_out, 2'b11);
    do_take();
    check("b2b_idle_valid", valid, 0);

    // Write to R3 while it is being captured in RD_B.
    start_fetch(3'd5, 3'd3, 2'b01, 1'b0);
    @(negedge clk);
    do_write(3'd3, 16'hAAAA);
    check("rdb_wr_valid", valid, 1);
    check("rdb_wr_a", a_out, 16'h1234);
    check("rdb_wr_b", b_out, exp_b_rdb);
    do_take();
    start_fetch(3'd3, 3'd3, 2'b00, 1'b0);
    wait_valid("r3_valid");
    check("r3_a", a_out, 16'hAAAA);
    check("r3_b", b_out, 16'hAAAA);
    do_take();

    // start pulsed during RD_A is ignored.
    do_write(3'd1, 16'h1111);
    start_fetch(3'd5, 3'd3, 2'b00, 1'b0);
    start = 1'b1; rn = 3'd1; rm = 3'd1; shift_in = 2'b10;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("ign_valid", valid, 1);
    check("ign_a", a_out, 16'h1234);
    check("ign_b", b_out, 16'hAAAA);
    check("ign_shift", shift_out, 2'b00);
    do_take();
    valid_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (valid) valid_cnt++;
      @(negedge clk);
    end
    check("ign_one_episode", valid_cnt, 0);

    // Asynchronous reset in the middle of RD_B.
    start_fetch(3'd5, 3'd3, 2'b01, 1'b0);
    @(negedge clk);
    check("pre_rst_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("arst_valid", valid, 0);
    check("arst_busy", busy, 0);
    check("arst_a", a_out, 0);
    check("arst_b", b_out, 0);
    check("arst_shift", shift_out, 0);
    @(negedge clk);
    reset = 1'b0;
    start_fetch(3'd5, 3'd5, 2'b00, 1'b0);
    wait_valid("post_rst_valid");
    check("post_rst_a", a_out, 0);
    check("post_rst_b", b_out, 0);
    do_take();

    // R0 is an ordinary register.
    do_write(3'd0, 16'h8001);
    start_fetch(3'd0, 3'd0, 2'b10, 1'b0);
    wait_valid("r0_valid");
    check("r0_a", a_out, 16'h8001);
    check("r0_b", b_out, 16'h8001);
    check("r0_shift", shift_out, 2'b10);
    do_take();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
